// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU decode/compute and an iterative
// shift-add multiplier that stalls the front of the pipe until the product
// is ready.
module ex_stage #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [1:0]      ALUOp_i,
   input  logic            ALUSrc_i,
   input  logic [9:0]      funct_i,
   input  logic [XLEN-1:0] RS1_i,
   input  logic [XLEN-1:0] RS2_i,
   input  logic [XLEN-1:0] IMM_i,
   input  logic [4:0]      RS1addr_i,
   input  logic [4:0]      RS2addr_i,
   input  logic            EXMEM_RegWrite_i,
   input  logic [4:0]      EXMEM_RDaddr_i,
   input  logic [XLEN-1:0] EXMEM_ALUResult_i,
   input  logic            MEMWB_RegWrite_i,
   input  logic [4:0]      MEMWB_RDaddr_i,
   input  logic [XLEN-1:0] MEMWB_WriteData_i,
   output logic [XLEN-1:0] ALUResult_o,
   output logic [XLEN-1:0] WriteData_o,
   output logic            Zero_o,
   output logic            stall_o
);

   localparam int CW = $clog2(MUL_CYCLES + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(MUL_CYCLES - 1);

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_BAD
   } alu_op_e;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

   logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_res;
   logic [4:0]      shamt;
   alu_op_e         alu_op;
   mul_state_e      state_q, state_d;
   logic            stall;
   logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
   logic [CW-1:0]   cnt_q;

   // Operand A forwarding: EX/MEM beats MEM/WB, x0 never forwarded
   always_comb begin
      op_a = RS1_i;
      if (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == RS1addr_i)
         op_a = EXMEM_ALUResult_i;
      else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RS1addr_i)
         op_a = MEMWB_WriteData_i;
   end

   // Operand RS2 forwarding, same priority; also the store data
   always_comb begin
      rs2_fwd = RS2_i;
      if (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == RS2addr_i)
         rs2_fwd = EXMEM_ALUResult_i;
      else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RS2addr_i)
         rs2_fwd = MEMWB_WriteData_i;
   end

   assign op_b        = ALUSrc_i ? IMM_i : rs2_fwd;
   assign shamt       = op_b[4:0];
   assign WriteData_o = rs2_fwd;

   // ALU control decode from ALUOp and funct fields
   always_comb begin
      alu_op = OP_BAD;
      case (ALUOp_i)
         2'b00: alu_op = OP_ADD;
         2'b01: alu_op = OP_SUB;
         2'b10: begin
            case (funct_i)
               10'b0000000_000: alu_op = OP_ADD;
               10'b0100000_000: alu_op = OP_SUB;
               10'b0000000_111: alu_op = OP_AND;
               10'b0000000_110: alu_op = OP_OR;
               10'b0000000_100: alu_op = OP_XOR;
               10'b0000000_001: alu_op = OP_SLL;
               10'b0000000_101: alu_op = OP_SRL;
               10'b0100000_101: alu_op = OP_SRA;
               10'b0000001_000: alu_op = OP_MUL;
               default:         alu_op = OP_BAD;
            endcase
         end
         default: begin
            case (funct_i[2:0])
               3'b000:  alu_op = OP_ADD;
               3'b111:  alu_op = OP_AND;
               3'b110:  alu_op = OP_OR;
               3'b100:  alu_op = OP_XOR;
               3'b001:  alu_op = OP_SLL;
               3'b101:  alu_op = IMM_i[10] ? OP_SRA : OP_SRL;
               default: alu_op = OP_BAD;
            endcase
         end
      endcase
   end

   // Single-cycle ALU; MUL and unlisted encodings yield zero here
   always_comb begin
      alu_res = '0;
      case (alu_op)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_a << shamt;
         OP_SRL:  alu_res = op_a >> shamt;
         OP_SRA:  alu_res = $signed(op_a) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   // Multiplier state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Multiplier next state and stall request
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (alu_op == OP_MUL) begin
               stall   = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt_q == LAST_ITER) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Reset releases the stall immediately, without waiting for a clock
   assign stall_o = stall & rst_i;

   // Shift-add datapath; operands are captured once so late forwarding cannot disturb them
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (state_q == IDLE && alu_op == OP_MUL) begin
         mcand_q  <= op_a;
         mplier_q <= op_b;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (state_q == BUSY) begin
         if (mplier_q[0]) acc_q <= acc_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
      end
   end

   assign ALUResult_o = (state_q == DONE) ? acc_q : alu_res;
   assign Zero_o      = (ALUResult_o == '0);

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed forwarding/ALU cases, random
// single-cycle ops against a reference model, and multiplier timing checks.
module tb_ex_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  ALUOp_i;
   logic        ALUSrc_i;
   logic [9:0]  funct_i;
   logic [31:0] RS1_i, RS2_i, IMM_i;
   logic [4:0]  RS1addr_i, RS2addr_i;
   logic        EXMEM_RegWrite_i;
   logic [4:0]  EXMEM_RDaddr_i;
   logic [31:0] EXMEM_ALUResult_i;
   logic        MEMWB_RegWrite_i;
   logic [4:0]  MEMWB_RDaddr_i;
   logic [31:0] MEMWB_WriteData_i;
   logic [31:0] ALUResult_o, WriteData_o;
   logic        Zero_o, stall_o;

   int vectors    = 0;
   int miscompares = 0;

   ex_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
      .funct_i(funct_i), .RS1_i(RS1_i), .RS2_i(RS2_i), .IMM_i(IMM_i),
      .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
      .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i),
      .EXMEM_ALUResult_i(EXMEM_ALUResult_i),
      .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_RDaddr_i(MEMWB_RDaddr_i),
      .MEMWB_WriteData_i(MEMWB_WriteData_i),
      .ALUResult_o(ALUResult_o), .WriteData_o(WriteData_o),
      .Zero_o(Zero_o), .stall_o(stall_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Value a source register actually sees after bypassing
   function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] rf);
      if (addr != 0 && EXMEM_RegWrite_i && EXMEM_RDaddr_i == addr) return EXMEM_ALUResult_i;
      if (addr != 0 && MEMWB_RegWrite_i && MEMWB_RDaddr_i == addr) return MEMWB_WriteData_i;
      return rf;
   endfunction

   function automatic logic [31:0] ref_sra(input logic [31:0] a, input int sh);
      logic [31:0] ones = 32'hFFFF_FFFF;
      return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
   endfunction

   // Expected single-cycle result from the current input set
   function automatic logic [31:0] ref_alu();
      logic [31:0] a, b;
      int sh;
      a  = ref_fwd(RS1addr_i, RS1_i);
      b  = ALUSrc_i ? IMM_i : ref_fwd(RS2addr_i, RS2_i);
      sh = int'(b % 32);
      case (ALUOp_i)
         2'd0: return a + b;
         2'd1: return a - b;
         2'd2: begin
            if (funct_i == 10'h000) return a + b;
            if (funct_i == 10'h100) return a - b;
            if (funct_i == 10'h007) return a & b;
            if (funct_i == 10'h006) return a | b;
            if (funct_i == 10'h004) return a ^ b;
            if (funct_i == 10'h001) return a << sh;
            if (funct_i == 10'h005) return a >> sh;
            if (funct_i == 10'h105) return ref_sra(a, sh);
            return 32'h0;
         end
         default: begin
            case (funct_i[2:0])
               3'd0: return a + b;
               3'd7: return a & b;
               3'd6: return a | b;
               3'd4: return a ^ b;
               3'd1: return a << sh;
               3'd5: return IMM_i[10] ? ref_sra(a, sh) : a >> sh;
               default: return 32'h0;
            endcase
         end
      endcase
   endfunction

   task automatic clear_inputs();
      ALUOp_i = 0; ALUSrc_i = 0; funct_i = 0; RS1_i = 0; RS2_i = 0; IMM_i = 0;
      RS1addr_i = 0; RS2addr_i = 0; EXMEM_RegWrite_i = 0; EXMEM_RDaddr_i = 0;
      EXMEM_ALUResult_i = 0; MEMWB_RegWrite_i = 0; MEMWB_RDaddr_i = 0; MEMWB_WriteData_i = 0;
   endtask

   // Compare all combinational outputs against the model for current inputs
   task automatic check_comb(input string tag);
      logic [31:0] exp;
      #2;
      exp = ref_alu();
      chk({tag, ".res"},   ALUResult_o, exp);
      chk({tag, ".zero"},  {31'b0, Zero_o}, {31'b0, exp == 32'h0});
      chk({tag, ".wdata"}, WriteData_o, ref_fwd(RS2addr_i, RS2_i));
      chk({tag, ".stall"}, {31'b0, stall_o}, 32'h0);
   endtask

   // Issue a MUL, count stall cycles (bounded) and check the product
   task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input bit perturb);
      int  n = 0;
      bit  done = 0;
      @(posedge clk_i); #1;
      clear_inputs();
      ALUOp_i = 2'd2; funct_i = 10'h008; RS1_i = a; RS2_i = b;
      RS1addr_i = 5'd1; RS2addr_i = 5'd2;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk_i);
         if (stall_o) begin
            n++;
            if (perturb && n >= 2) begin
               MEMWB_RegWrite_i  = 1'b1;
               MEMWB_RDaddr_i    = 5'd1;
               MEMWB_WriteData_i = $urandom;
            end
         end else done = 1;
      end
      chk({tag, ".stalls"}, 32'(n), 32'd33);
      chk({tag, ".prod"}, ALUResult_o, a * b);
      chk({tag, ".stall_lo"}, {31'b0, stall_o}, 32'h0);
   endtask

   initial begin
      logic [9:0] functs [10];
      functs = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h004,
                 10'h001, 10'h005, 10'h105, 10'h003, 10'h2A5};

      rst_i = 1'b0;
      clear_inputs();
      #2;
      chk("rst.res",   ALUResult_o, 32'h0);
      chk("rst.zero",  {31'b0, Zero_o}, 32'h1);
      chk("rst.wdata", WriteData_o, 32'h0);
      chk("rst.stall", {31'b0, stall_o}, 32'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;

      // Forwarding priority: EX/MEM wins over MEM/WB
      @(posedge clk_i); #1;
      clear_inputs();
      RS1addr_i = 5; EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 5; EXMEM_ALUResult_i = 32'h11;
      MEMWB_RegWrite_i = 1; MEMWB_RDaddr_i = 5; MEMWB_WriteData_i = 32'h22;
      RS1_i = 32'h33; ALUSrc_i = 1; IMM_i = 1;
      check_comb("fwd_prio");
      chk("fwd_prio.const", ALUResult_o, 32'h12);

      // x0 is never forwarded
      clear_inputs();
      EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 0; EXMEM_ALUResult_i = 32'hFFFF; ALUSrc_i = 1;
      check_comb("x0");
      chk("x0.zero_const", {31'b0, Zero_o}, 32'h1);

      // Shift/sub sweep
      clear_inputs();
      RS1_i = 32'hF000_0000; RS2_i = 4; RS2addr_i = 3; ALUOp_i = 2;
      funct_i = 10'h105; check_comb("sra"); chk("sra.const", ALUResult_o, 32'hFF00_0000);
      funct_i = 10'h005; check_comb("srl"); chk("srl.const", ALUResult_o, 32'h0F00_0000);
      funct_i = 10'h100; check_comb("sub"); chk("sub.const", ALUResult_o, 32'hEFFF_FFFC);
      ALUOp_i = 3; funct_i = 10'h005; ALUSrc_i = 1; IMM_i = 32'h404;
      check_comb("srai"); chk("srai.const", ALUResult_o, 32'hFF00_0000);

      // Multiplier: basic, back-to-back, wrap, operand stability
      do_mul("mul7x6", 32'd7, 32'd6, 0);
      do_mul("mulFFx2", 32'hFFFF_FFFF, 32'd2, 0);
      do_mul("mul_stable", $urandom, $urandom, 1);

      // Reset in the middle of BUSY
      @(posedge clk_i); #1;
      clear_inputs();
      ALUOp_i = 2; funct_i = 10'h008; RS1_i = 32'd5; RS2_i = 32'd5;
      repeat (11) @(negedge clk_i);
      chk("midrst.busy", {31'b0, stall_o}, 32'h1);
      rst_i = 1'b0;
      #1;
      chk("midrst.drop", {31'b0, stall_o}, 32'h0);
      clear_inputs();
      @(negedge clk_i);
      rst_i = 1'b1;
      do_mul("mul3x3", 32'd3, 32'd3, 0);

      // Random single-cycle operations
      for (int i = 0; i < 300; i++) begin
         @(posedge clk_i); #1;
         ALUOp_i  = 2'($urandom_range(0, 3));
         funct_i  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : functs[$urandom_range(0, 9)];
         if (ALUOp_i == 2'd2 && funct_i == 10'h008) funct_i = 10'h000;
         ALUSrc_i = 1'($urandom);
         RS1_i = $urandom; RS2_i = $urandom; IMM_i = $urandom;
         if ($urandom_range(0, 7) == 0) RS1_i = 0;
         RS1addr_i = 5'($urandom_range(0, 7)); RS2addr_i = 5'($urandom_range(0, 7));
         EXMEM_RegWrite_i = 1'($urandom); EXMEM_RDaddr_i = 5'($urandom_range(0, 7));
         EXMEM_ALUResult_i = $urandom;
         MEMWB_RegWrite_i = 1'($urandom); MEMWB_RDaddr_i = 5'($urandom_range(0, 7));
         MEMWB_WriteData_i = $urandom;
         check_comb("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
